// File: rtl/booth_arbiter.sv
// Round-robin front end that time-shares one sequential multiplier: grant -> issue -> run -> respond.
// Response is valid WIDTH+3 cycles after the grant and is held until rsp_ready; no grants while busy.
module booth_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_x,
  input  logic [NREQ*WIDTH-1:0] req_y,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [2*WIDTH-1:0]    rsp_z,
  output logic                  rsp_err,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      mul_x,
  output logic [WIDTH-1:0]      mul_y,
  output logic                  mul_start,
  input  logic [2*WIDTH-1:0]    mul_z,
  input  logic                  mul_busy
);

  localparam int CW = $clog2(WIDTH + 3);

  typedef enum logic [1:0] {IDLE, ISSUE, RUN, RESP} state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [WIDTH-1:0]   op_x_q, op_x_d;
  logic [WIDTH-1:0]   op_y_q, op_y_d;
  logic [CW-1:0]      rcnt_q, rcnt_d;
  logic [2*WIDTH-1:0] z_q, z_d;
  logic               err_q, err_d;

  logic               gnt_vld;
  logic [IDW-1:0]     gnt_idx;
  logic [IDW-1:0]     cand;

  // Scan downwards so the candidate closest to ptr is the one left standing.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = ptr_q + IDW'(k);
      if (req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    op_x_d    = op_x_q;
    op_y_d    = op_y_q;
    rcnt_d    = rcnt_q;
    z_d       = z_q;
    err_d     = err_q;
    req_ready = '0;
    mul_start = 1'b0;
    rsp_valid = 1'b0;
    rsp_id    = '0;
    rsp_z     = '0;
    rsp_err   = 1'b0;

    case (state_q)
      IDLE: begin
        if (gnt_vld && !rst) begin
          req_ready[gnt_idx] = 1'b1;
          op_x_d  = req_x[gnt_idx*WIDTH +: WIDTH];
          op_y_d  = req_y[gnt_idx*WIDTH +: WIDTH];
          id_d    = gnt_idx;
          ptr_d   = gnt_idx + IDW'(1);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mul_start = 1'b1;
        rcnt_d    = '0;
        state_d   = RUN;
      end
      RUN: begin
        rcnt_d = rcnt_q + CW'(1);
        if (!mul_busy) begin
          // Busy low on the first RUN cycle means the start strobe was never seen.
          if (rcnt_q == '0) begin
            err_d = 1'b1;
          end else begin
            z_d   = mul_z;
            err_d = 1'b0;
          end
          state_d = RESP;
        end else if (rcnt_q == CW'(WIDTH + 2)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_id    = id_q;
        rsp_z     = err_q ? '0 : z_q;
        rsp_err   = err_q;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mul_x = op_x_q;
  assign mul_y = op_y_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      op_x_q  <= '0;
      op_y_q  <= '0;
      rcnt_q  <= '0;
      z_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      op_x_q  <= op_x_d;
      op_y_q  <= op_y_d;
      rcnt_q  <= rcnt_d;
      z_q     <= z_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/booth_arbiter.md
# booth_arbiter

Round-robin arbiter and sequencer that shares one `booth` sequential signed multiplier among NREQ requesters. It accepts one request at a time over a valid/ready handshake and drives the multiplier's start/operand inputs. It waits out the multiplier's busy window, captures the product, and returns it on a shared response channel tagged with the requester index. A watchdog flags a multiplier that fails to follow its expected busy profile.

## Interface
- WIDTH, 16: operand width; must equal the attached multiplier's WIDTH.
- NREQ, 4: number of requesters, power of two in 2..8; IDW = $clog2(NREQ).
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high. The multiplier's rst_n is driven as ~rst at integration.
- req_valid  in  NREQ  per-requester request.
- req_x, req_y  in  NREQ*WIDTH each  signed operands; requester i uses slice [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  one-hot grant pulse; the operands of that requester are latched.
- rsp_valid  out  1  result available.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_z  out  2*WIDTH  signed product.
- rsp_err  out  1  watchdog error; rsp_z=0 when set.
- rsp_ready  in  1  consumer accepts the response.
- mul_x, mul_y  out  WIDTH  operands to the multiplier.
- mul_start  out  1  one-cycle start strobe.
- mul_z  in  2*WIDTH  multiplier product.
- mul_busy  in  1  multiplier busy.

## Operation
- FSM states: IDLE, ISSUE, RUN, RESP. Reset enters IDLE.
- IDLE:
  - If any req_valid is high, grant the first set bit at or after index ptr, wrapping around.
  - Pulse req_ready[g] combinationally in the same cycle.
  - Latch req_x/req_y slice g into op_x/op_y and g into id_reg.
  - Set ptr <= g+1 mod NREQ. Go to ISSUE.
- ISSUE (exactly 1 cycle): mul_start=1 with mul_x=op_x, mul_y=op_y. Clear rcnt. Go to RUN.
- RUN: rcnt increments every cycle.
  - rcnt==0 and mul_busy=0: the multiplier did not start. Set err, go to RESP.
  - rcnt>0 and mul_busy=0: the multiplication is done. Capture mul_z into z_reg, err=0, go to RESP.
  - rcnt==WIDTH+2 and mul_busy=1: overrun. Set err, go to RESP.
- RESP: rsp_valid=1, rsp_id=id_reg, rsp_z=(err?0:z_reg), rsp_err=err. Hold these until rsp_ready=1, then go to IDLE.
- mul_x/mul_y always drive op_x/op_y. The multiplier samples them only on its start cycle.
- Only one operation is outstanding at a time. No new grant is issued while in ISSUE, RUN or RESP.
- Requester rule: hold req_valid and operands stable until req_ready. Deasserting req_valid before the grant withdraws the request and is legal.
- Product is the full 2*WIDTH two's-complement result; no truncation.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_z=0, rsp_err=0, mul_start=0, mul_x=mul_y=0, ptr=0.
- Cycle timeline (cycle 0 = grant in IDLE):
  - Cycle 1: ISSUE, mul_start=1.
  - Cycles 2..WIDTH+1: RUN with mul_busy=1 (WIDTH cycles).
  - Cycle WIDTH+2: mul_busy=0; mul_z is captured at the end of this cycle.
  - Cycle WIDTH+3: rsp_valid=1 (cycle 19 for WIDTH=16).
- On capture, the multiplier is in its one-cycle output state and ignores start. It is back in idle by the response cycle, so back-to-back issue is always safe.
- With rsp_ready tied high, the next grant occurs at cycle WIDTH+4. Sustained throughput is one product per WIDTH+4 cycles (20 for WIDTH=16).
- rsp_ready low stalls in RESP indefinitely; outputs stay stable. New requests wait.
- Simultaneous requests: exactly one grant per IDLE visit, in round-robin order from ptr.
- rst=1 in any state: FSM goes to IDLE at the next edge, all outputs take reset values, and any in-flight result is discarded. The multiplier is reset by the same signal.

## Test plan
- Single request, WIDTH=16, req 2: x=3, y=-5 → req_ready[2] at cycle 0, mul_start at cycle 1, rsp_valid at cycle 19 with rsp_z=32'hFFFFFFF1, rsp_id=2, rsp_err=0.
- Corner operands: x=-32768, y=-32768 → rsp_z=32'h40000000. Also x=32767, y=-32768 → 32'hC0008000. Also x=0, y=-1 → 0.
- Requests 0, 1 and 3 held continuously with rsp_ready=1 → grant order 0,1,3,0,...; rsp_valid pulses spaced 20 cycles apart; each rsp_id matches its operands.
- rsp_ready held low 10 cycles after rsp_valid → rsp_z/rsp_id stable throughout; next req_ready only after rsp_ready is accepted.
- Watchdog, using a stub multiplier in place of the real one:
  - Stub never raises busy → rsp_err=1, rsp_z=0 at cycle 3.
  - Stub holds busy high → rsp_err=1 after rcnt reaches 18.
- rst asserted at cycle 8 of an operation → next cycle all outputs are 0 and the FSM is in IDLE. A new request after reset completes correctly, and ptr=0 gives requester 0 priority.
